// File: rtl/spi_tx_fifo.sv
// SPI transmit buffer: a circular FIFO with a one-byte prefetch holding register
// that the serial shifter loads from, plus full/empty/level and sticky error flags.
module spi_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             S_CLK,
    input  logic             CLR,
    input  logic             SENDER_WRITE,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             SHIFT_LOAD,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             SENDER_BUFFER_FULL_STATE,
    output logic             SENDER_FULL_STATE,
    output logic             SENDER_EMPTY_STATE,
    output logic [CNT_W-1:0] FIFO_LEVEL,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic full;
    logic accept;
    logic consume;
    logic prefetch;

    // Full is judged on the registered count, so a same-cycle prefetch never frees a slot for a write.
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign accept   = SENDER_WRITE & ~full;
    assign consume  = SHIFT_LOAD & hold_vld_q;
    assign prefetch = (~hold_vld_q | consume) & (cnt_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q + CNT_W'(accept) - CNT_W'(prefetch);
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        ovf_d      = ovf_q | (SENDER_WRITE & full);
        unf_d      = unf_q | (SHIFT_LOAD & ~hold_vld_q);

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        // Holding data is left in place on a plain consume; only the valid bit drops.
        if (prefetch) begin
            hold_d     = mem_q[rd_ptr_q];
            hold_vld_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else if (consume) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage array carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge S_CLK) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= DATA_IN;
        end
    end

    assign DATA_OUT                 = hold_q;
    assign SENDER_BUFFER_FULL_STATE = hold_vld_q;
    assign SENDER_FULL_STATE        = full;
    assign SENDER_EMPTY_STATE       = (cnt_q == '0) & ~hold_vld_q;
    assign FIFO_LEVEL               = cnt_q;
    assign OVERFLOW                 = ovf_q;
    assign UNDERFLOW                = unf_q;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Bench for spi_tx_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_spi_tx_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             wr = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             ld = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             bfs, fulls, emptys, ovf, unf;
    logic [CNT_W-1:0] level;

    spi_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .S_CLK(clk),
        .CLR(clr),
        .SENDER_WRITE(wr),
        .DATA_IN(din),
        .SHIFT_LOAD(ld),
        .DATA_OUT(dout),
        .SENDER_BUFFER_FULL_STATE(bfs),
        .SENDER_FULL_STATE(fulls),
        .SENDER_EMPTY_STATE(emptys),
        .FIFO_LEVEL(level),
        .OVERFLOW(ovf),
        .UNDERFLOW(unf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: queued bytes, holding byte/valid, sticky flags.
    logic [WIDTH-1:0] q_m[$];
    logic [WIDTH-1:0] hd_m = '0;
    bit               hv_m = 1'b0;
    bit               ovf_m = 1'b0;
    bit               unf_m = 1'b0;
    logic [WIDTH-1:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit c, input bit w, input logic [WIDTH-1:0] d, input bit l);
        bit full_now, cons, pf;
        if (c) begin
            q_m.delete();
            hv_m = 0; hd_m = '0; ovf_m = 0; unf_m = 0;
        end else begin
            full_now = (q_m.size() == DEPTH);
            cons     = l && hv_m;
            pf       = (!hv_m || cons) && (q_m.size() != 0);
            if (w && full_now) ovf_m = 1;
            if (l && !hv_m)    unf_m = 1;
            if (pf) begin
                hd_m = q_m.pop_front();
                hv_m = 1;
            end else if (cons) begin
                hv_m = 0;
            end
            if (w && !full_now) q_m.push_back(d);
        end
    endtask

    // One clock: drive at the falling edge, log bytes the shifter takes, advance the model.
    task automatic cycle(input bit c, input bit w, input logic [WIDTH-1:0] d, input bit l);
        clr = c; wr = w; din = d; ld = l;
        if (l && bfs && !c) got.push_back(dout);
        @(posedge clk);
        model_step(c, w, d, l);
        @(negedge clk);
        clr = 0; wr = 0; ld = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!emptys && n < 40) begin
            cycle(0, 0, '0, hv_m);
            n++;
        end
        if (n >= 40) check({name, "_drain_timeout"}, 32'(emptys), 32'd1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("level", 32'(level), 32'(q_m.size()));
            check("full", 32'(fulls), 32'(q_m.size() == DEPTH));
            check("empty", 32'(emptys), 32'((q_m.size() == 0) && !hv_m));
            check("buf_full", 32'(bfs), 32'(hv_m));
            check("overflow", 32'(ovf), 32'(ovf_m));
            check("underflow", 32'(unf), 32'(unf_m));
            if (hv_m) check("data_out", 32'(dout), 32'(hd_m));
        end
    end

    initial begin
        @(negedge clk);
        cycle(1, 0, '0, 0);
        chk_en = 1;

        // Reset then idle
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_bfs", 32'(bfs), 32'd0);
        check("rst_full", 32'(fulls), 32'd0);
        check("rst_empty", 32'(emptys), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
        for (int i = 0; i < 10; i++) cycle(0, 0, '0, 0);
        check("idle_empty", 32'(emptys), 32'd1);

        // Single byte
        cycle(0, 1, 8'hA5, 0);
        check("single_level1", 32'(level), 32'd1);
        check("single_empty0", 32'(emptys), 32'd0);
        cycle(0, 0, '0, 0);
        check("single_dout", 32'(dout), 32'hA5);
        check("single_bfs", 32'(bfs), 32'd1);
        check("single_level0", 32'(level), 32'd0);
        cycle(0, 0, '0, 1);
        check("single_empty1", 32'(emptys), 32'd1);

        // Fill with 0x01..0x0A, 0x0A dropped
        cycle(1, 0, '0, 0);
        for (int i = 1; i <= 10; i++) cycle(0, 1, 8'(i), 0);
        check("fill_dout", 32'(dout), 32'h01);
        check("fill_level", 32'(level), 32'd8);
        check("fill_full", 32'(fulls), 32'd1);
        check("fill_ovf", 32'(ovf), 32'd1);
        got.delete();
        drain("fill");
        check("fill_count", 32'(got.size()), 32'd9);
        for (int i = 0; i < got.size(); i++) check("fill_order", 32'(got[i]), 32'(i + 1));

        // Simultaneous write and load at level 4
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h10 + i), 0);
        check("sim_pre_level", 32'(level), 32'd4);
        got.delete();
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 8'(8'h15 + i), 1);
            check("sim_level", 32'(level), 32'd4);
        end
        drain("sim");
        check("sim_count", 32'(got.size()), 32'd25);
        for (int i = 0; i < got.size(); i++) check("sim_order", 32'(got[i]), 32'(8'h10 + i));
        check("sim_unf", 32'(unf), 32'd0);

        // Underflow
        cycle(1, 0, '0, 0);
        cycle(0, 0, '0, 1);
        check("unf_set", 32'(unf), 32'd1);
        check("unf_level", 32'(level), 32'd0);
        check("unf_empty", 32'(emptys), 32'd1);
        for (int i = 0; i < 5; i++) cycle(0, 0, '0, 0);
        check("unf_sticky", 32'(unf), 32'd1);

        // Reset mid-operation at level 5 with a same-cycle write
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 8'(8'h50 + i), 0);
        check("mid_level5", 32'(level), 32'd5);
        cycle(1, 1, 8'h77, 0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_bfs", 32'(bfs), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'h0);
        check("mid_rst_empty", 32'(emptys), 32'd1);
        check("mid_rst_unf", 32'(unf), 32'd0);
        cycle(0, 1, 8'h3C, 0);
        cycle(0, 0, '0, 0);
        check("mid_first_dout", 32'(dout), 32'h3C);
        check("mid_first_level", 32'(level), 32'd0);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spi_tx_fifo.md
# spi_tx_fifo

Transmit-side buffer of the SPI interface: accepts bytes from the host write port, queues them in a DEPTH-entry circular FIFO, and prefetches the head into a one-byte holding register that the serial shifter loads from. It sits directly upstream of the status-combination stage and produces the sender full, empty and buffer-full flags that stage packs into the STATUS byte. It also adds sticky overflow and underflow error flags.

## Interface
- DEPTH, 8: FIFO entries, excluding the holding register; power of two, at least 2.
- WIDTH, 8: data width in bits.
- S_CLK  in  1  single clock; all state updates on the rising edge.
- CLR  in  1  reset, synchronous, active-high.
- SENDER_WRITE  in  1  host write strobe; one byte per cycle while high.
- DATA_IN  in  WIDTH  write data, sampled with SENDER_WRITE.
- SHIFT_LOAD  in  1  shifter takes DATA_OUT this cycle.
- DATA_OUT  out  WIDTH  holding-register contents.
- SENDER_BUFFER_FULL_STATE  out  1  holding register valid (DATA_OUT meaningful).
- SENDER_FULL_STATE  out  1  FIFO count == DEPTH.
- SENDER_EMPTY_STATE  out  1  FIFO count == 0 and holding register empty (nothing left to send).
- FIFO_LEVEL  out  clog2(DEPTH+1)  FIFO count 0..DEPTH, excluding the holding register.
- OVERFLOW  out  1  sticky: a write was rejected.
- UNDERFLOW  out  1  sticky: SHIFT_LOAD was asserted with the holding register empty.

## Operation
- Storage:
  - DEPTH x WIDTH array.
  - Write and read pointers of clog2(DEPTH) bits each; both wrap modulo DEPTH.
  - Count register of clog2(DEPTH+1) bits.
- Write accept: SENDER_WRITE & ~SENDER_FULL_STATE.
  - On accept, store DATA_IN at the write pointer and increment the pointer.
  - A write while full is dropped: no pointer or count change, OVERFLOW set.
  - The full check uses the registered count. A write is rejected when full even if a prefetch pops in the same cycle.
- Holding-register consume: SHIFT_LOAD & SENDER_BUFFER_FULL_STATE.
  - SHIFT_LOAD while the holding register is empty is ignored apart from setting UNDERFLOW.
- Prefetch: fires when (holding empty OR consume this cycle) AND count != 0.
  - The FIFO head moves into the holding register, the read pointer increments, and the holding register stays or becomes valid.
  - When consume fires with no prefetch, the holding register becomes invalid.
- Count next value: count + accept − prefetch. Simultaneous accept and prefetch leave the count unchanged.
- No write bypass: an accepted byte always passes through the FIFO, even when the FIFO and holding register are empty.
- Bytes leave on DATA_OUT in strict write order; no byte is lost or duplicated.
- The holding register's data is not cleared on consume; DATA_OUT is don't-care while SENDER_BUFFER_FULL_STATE=0.
- CLR:
  - Clears pointers, count, holding-valid, OVERFLOW, UNDERFLOW and DATA_OUT (to 0).
  - Takes priority over a same-cycle write or load; all FIFO contents are discarded.
  - Array contents are not reset.

## Timing
- Reset values:
  - DATA_OUT=0
  - SENDER_BUFFER_FULL_STATE=0
  - SENDER_FULL_STATE=0
  - SENDER_EMPTY_STATE=1
  - FIFO_LEVEL=0
  - OVERFLOW=0
  - UNDERFLOW=0
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.
- Write-to-visible latency from an empty state:
  - Write in cycle N gives FIFO_LEVEL=1 after edge N.
  - After edge N+1: holding valid, FIFO_LEVEL=0, SENDER_EMPTY_STATE=0 from edge N onward.
- Back-to-back loads: with SHIFT_LOAD held high and the FIFO non-empty, a new byte appears on DATA_OUT every cycle.
- Full flags:
  - SENDER_FULL_STATE asserts the edge after the DEPTH-th stored byte.
  - It deasserts the edge after the first prefetch.
- Sticky flags set on the edge following the offending cycle and stay set until CLR.

## Test plan
- Reset then idle:
  - After CLR, check the reset value of every output.
  - Hold SENDER_WRITE=0 for 10 cycles -> no change.
- Single byte, write 0xA5 in cycle N:
  - FIFO_LEVEL=1 after N, then DATA_OUT=0xA5, SENDER_BUFFER_FULL_STATE=1 and FIFO_LEVEL=0 after N+1.
  - SHIFT_LOAD one cycle -> SENDER_EMPTY_STATE=1.
- Fill, DEPTH=8, no loads, write 0x01..0x0A:
  - Holding=0x01, FIFO_LEVEL=8, SENDER_FULL_STATE=1, OVERFLOW=1.
  - Byte 0x0A is dropped.
  - Drain -> DATA_OUT sequence 0x01..0x09 exactly.
- Simultaneous events:
  - At FIFO_LEVEL=4 with holding valid, assert SENDER_WRITE and SHIFT_LOAD together for 20 cycles with incrementing data.
  - FIFO_LEVEL stays 4, order is preserved, and the pointers wrap at least twice.
- Underflow: SHIFT_LOAD with the holding register empty -> UNDERFLOW=1, no other state change; UNDERFLOW stays set until CLR.
- Reset mid-operation:
  - At FIFO_LEVEL=5, assert CLR in the same cycle as SENDER_WRITE=1 -> all reset values next cycle and the write is discarded.
  - A subsequent write of 0x3C emerges first on DATA_OUT.
